// File: rtl/seg7_scan4.sv
// seg7_scan4: 4-digit multiplexed 7-segment driver with anti-ghost blanking,
// leading-zero suppression and frame-aligned value updates.
module seg7_scan4 #(
  parameter int SCAN_DIV = 250000,
  parameter int BLANK    = 4,
  parameter int HEX      = 0,
  parameter int LZB      = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [15:0] DIN,
  input  logic [3:0]  DPIN,
  output logic        BUSY,
  output logic        FRAME,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  K
);
  localparam int TW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [TW-1:0] tim_q, tim_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   dsp_q, dsp_d;
  logic [3:0]    dps_q, dps_d;
  logic [19:0]   pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          frame_q;
  logic [3:0]    k_q, k_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          wrap, bnd, blank, lz;
  logic [3:0]    nib;
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction
  assign wrap  = tim_q == TW'(SCAN_DIV - 1);
  assign bnd   = wrap && idx_q == 2'd3;
  assign blank = tim_q < TW'(BLANK);
  assign nib   = dsp_q[{idx_q, 2'b00} +: 4];
  // A digit is a leading zero when it and every digit above it are zero.
  assign lz    = LZB != 0 && idx_q != 2'd0 && (dsp_q >> {idx_q, 2'b00}) == 16'h0;
  always_comb begin
    tim_d  = wrap ? '0 : tim_q + TW'(1);
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    dsp_d  = dsp_q;
    dps_d  = dps_q;
    pend_d = pend_q;
    busy_d = busy_q;
    if (bnd) begin
      busy_d = 1'b0;
      if (LOAD || busy_q) {dsp_d, dps_d} = LOAD ? {DIN, DPIN} : pend_q;
    end else if (LOAD) begin
      pend_d = {DIN, DPIN};
      busy_d = 1'b1;
    end
    k_d   = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = (blank || lz || (HEX == 0 && nib > 4'd9)) ? 7'h7F : glyph(nib);
    dp_d  = blank | ~dps_q[idx_q];
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tim_q   <= '0;
      idx_q   <= '0;
      dsp_q   <= '0;
      dps_q   <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
      k_q     <= 4'b1111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      tim_q   <= tim_d;
      idx_q   <= idx_d;
      dsp_q   <= dsp_d;
      dps_q   <= dps_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      frame_q <= bnd;
      k_q     <= k_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end
  assign BUSY  = busy_q;
  assign FRAME = frame_q;
  assign K     = k_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
endmodule

// File: tb/tb_seg7_scan4.sv
// tb_seg7_scan4: scoreboard bench for seg7_scan4, one HEX=0 and one HEX=1 instance in lockstep.
module tb_seg7_scan4;
  typedef struct packed {
    logic [15:0]     din;
    logic [3:0]      dpin;
    logic [3:0][6:0] s0;
    logic [3:0][6:0] s1;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  dpin = '0;
  logic        busy, frame, dp, busy_h, frame_h, dp_h;
  logic [6:0]  seg, seg_h;
  logic [3:0]  k, k_h;
  int          pass_n = 0, total_n = 0, edge_n = 0;
  vec_t        vt[6];
  vec_t        sb[$];
  vec_t        cur;
  seg7_scan4 #(.SCAN_DIV(8), .BLANK(2), .HEX(0), .LZB(1)) u_dut (
    .CLK(clk), .RST(rst), .LOAD(load), .DIN(din), .DPIN(dpin),
    .BUSY(busy), .FRAME(frame), .seg(seg), .dp(dp), .K(k));
  seg7_scan4 #(.SCAN_DIV(8), .BLANK(2), .HEX(1), .LZB(1)) u_hex (
    .CLK(clk), .RST(rst), .LOAD(load), .DIN(din), .DPIN(dpin),
    .BUSY(busy_h), .FRAME(frame_h), .seg(seg_h), .dp(dp_h), .K(k_h));
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p,
                              input logic [27:0] a, input logic [27:0] b);
    vec_t v;
    v.din = d; v.dpin = p; v.s0 = a; v.s1 = b;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask
  task automatic adv(input int e);
    while (edge_n < e) begin
      @(negedge clk);
      edge_n++;
    end
  endtask
  task automatic sync_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 40);
    chk("frame_seen", {31'd0, frame}, 32'd1);
    edge_n = 0;
  endtask
  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; din = d; dpin = p;
    @(negedge clk);
    edge_n++;
    load = 1'b0;
  endtask
  task automatic show_frame(input vec_t v);
    adv(1);
    chk("frame_pulse_width", {31'd0, frame}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      adv(8 * i + 2);
      chk($sformatf("blank_k%0d", i), {28'd0, k}, 32'hF);
      chk($sformatf("blank_seg%0d", i), {25'd0, seg}, 32'h7F);
      chk($sformatf("blank_dp%0d", i), {31'd0, dp}, 32'd1);
      adv(8 * i + 5);
      chk($sformatf("k%0d", i), {28'd0, k}, {28'd0, ~(4'b0001 << i)});
      chk($sformatf("k_hex%0d", i), {28'd0, k_h}, {28'd0, ~(4'b0001 << i)});
      chk($sformatf("seg%0d_%h", i, v.din), {25'd0, seg}, {25'd0, v.s0[i]});
      chk($sformatf("seg_hex%0d_%h", i, v.din), {25'd0, seg_h}, {25'd0, v.s1[i]});
      chk($sformatf("dp%0d_%h", i, v.din), {31'd0, dp}, {31'd0, ~v.dpin[i]});
    end
  endtask
  initial begin
    // glyph fields are {digit3, digit2, digit1, digit0}
    vt[0] = mk(16'h1234, 4'b0100, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                                  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    vt[1] = mk(16'h0070, 4'b0000, {7'h7F, 7'h7F, 7'b1111000, 7'b1000000},
                                  {7'h7F, 7'h7F, 7'b1111000, 7'b1000000});
    vt[2] = mk(16'h00AF, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h7F},
                                  {7'h7F, 7'h7F, 7'b0001000, 7'b0001110});
    vt[3] = mk(16'h0000, 4'b1010, {7'h7F, 7'h7F, 7'h7F, 7'b1000000},
                                  {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    vt[4] = mk(16'h8096, 4'b1111, {7'b0000000, 7'b1000000, 7'b0010000, 7'b0000010},
                                  {7'b0000000, 7'b1000000, 7'b0010000, 7'b0000010});
    vt[5] = mk(16'h05CD, 4'b0010, {7'h7F, 7'b0010010, 7'h7F, 7'h7F},
                                  {7'h7F, 7'b0010010, 7'b1000110, 7'b0100001});
    repeat (3) @(negedge clk);
    chk("rst_k", {28'd0, k}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      sync_frame();
      adv(10);
      do_load(vt[j].din, vt[j].dpin);
      sb.push_back(vt[j]);
      chk("busy_after_load", {31'd0, busy}, 32'd1);
      sync_frame();
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      show_frame(sb.pop_front());
    end
    // two loads in one frame: only the later one may ever be displayed
    sync_frame();
    adv(10);
    do_load(16'h1111, 4'b0000);
    adv(20);
    do_load(16'h2222, 4'b0000);
    sb.push_back(mk(16'h2222, 4'b0000, {4{7'b0100100}}, {4{7'b0100100}}));
    sync_frame();
    show_frame(sb.pop_front());
    // load landing exactly on the boundary overrides a pending value
    sync_frame();
    adv(10);
    do_load(16'h9999, 4'b0000);
    chk("busy_pend9999", {31'd0, busy}, 32'd1);
    adv(31);
    do_load(16'h5555, 4'b0000);
    sb.push_back(mk(16'h5555, 4'b0000, {4{7'b0010010}}, {4{7'b0010010}}));
    chk("bnd_load_frame", {31'd0, frame}, 32'd1);
    chk("bnd_load_busy", {31'd0, busy}, 32'd0);
    edge_n = 0;
    show_frame(sb[0]);
    sync_frame();
    chk("bnd_load_busy_next", {31'd0, busy}, 32'd0);
    show_frame(sb.pop_front());
    // asynchronous reset in the middle of slot 2 with a value pending
    sync_frame();
    adv(10);
    do_load(16'h4321, 4'b0000);
    adv(21);
    rst = 1'b1;
    #1;
    chk("arst_k", {28'd0, k}, 32'hF);
    chk("arst_seg", {25'd0, seg}, 32'h7F);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_frame", {31'd0, frame}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_k1", {28'd0, k}, 32'hF);
    @(negedge clk);
    chk("rel_k2", {28'd0, k}, 32'hF);
    @(negedge clk);
    chk("rel_k3", {28'd0, k}, 32'hE);
    chk("rel_seg3", {25'd0, seg}, {25'd0, 7'b1000000});
    chk("rel_busy", {31'd0, busy}, 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
